// File: rtl/spi_word_dispatcher.sv
// spi_word_dispatcher
//   Brings 32-bit game words from the microcontroller SPI link into the
//   pxl_clk domain, queues them in a small FIFO and releases each one to a
//   single sink (score/lifebar, timer/mouse or the octagon ring buffer).
//   Release can be restricted to vertical blanking, and ring occupancy is
//   tracked so the ring is never overrun or retired below empty.
//
// Build option: DISPATCH_VBLANK_GATE_EN
//   defined   -> words are released only while vblank is high
//   undefined -> release gate is always open and vblank is ignored
//
// Parameters
//   FIFO_DEPTH  word FIFO entries (power of two, >= 2)
//   RING_SLOTS  octagon ring-buffer capacity
//
// Ports
//   pxl_clk      pixel clock, the only clock
//   reset        synchronous, active-high
//   sck/sdi/cs   asynchronous SPI pins (sample on sck fall, MSB first, cs active-high)
//   vblank       vertical blanking
//   score_valid  one-cycle strobe, word_out is a type-00 word
//   timer_valid  one-cycle strobe, word_out is a type-01 word
//   oct_valid    one-cycle strobe, word_out is a type-11 ring add/retire
//   word_out     last word popped from the FIFO, held between strobes
//   oct_count    live ring entries
//   fifo_level   FIFO occupancy
//   drop_count   dropped-word counter, saturating at 255
//   busy         FSM active or FIFO non-empty
module spi_word_dispatcher #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RING_SLOTS = 8
) (
  input  logic        pxl_clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        sdi,
  input  logic        cs,
  input  logic        vblank,
  output logic        score_valid,
  output logic        timer_valid,
  output logic        oct_valid,
  output logic [31:0] word_out,
  output logic [3:0]  oct_count,
  output logic [2:0]  fifo_level,
  output logic [7:0]  drop_count,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  RING_FULL = 4'(RING_SLOTS);

  typedef enum logic [1:0] {IDLE, WAIT_BLANK, ISSUE} state_t;

  // ---------------- input synchronizers ----------------
  logic [1:0] sck_sync, sdi_sync, cs_sync;
  logic       sck_prev;
  logic       sck_fall;

  always_ff @(posedge pxl_clk) begin
    if (reset) begin
      sck_sync <= '0;
      sdi_sync <= '0;
      cs_sync  <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], sck};
      sdi_sync <= {sdi_sync[0], sdi};
      cs_sync  <= {cs_sync[0], cs};
      sck_prev <= sck_sync[1];
    end
  end

  assign sck_fall = sck_prev & ~sck_sync[1];

  // ---------------- shifter ----------------
  logic [31:0] shreg;
  logic [4:0]  bitcnt;
  logic        word_done;

  always_ff @(posedge pxl_clk) begin
    if (reset) begin
      shreg     <= '0;
      bitcnt    <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (!cs_sync[1]) begin
        bitcnt <= '0;
      end else if (sck_fall) begin
        shreg <= {shreg[30:0], sdi_sync[1]};
        if (bitcnt == 5'd31) begin
          bitcnt    <= '0;
          word_done <= 1'b1;
        end else begin
          bitcnt <= bitcnt + 5'd1;
        end
      end
    end
  end

  // ---------------- word FIFO ----------------
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, level;
  logic        fifo_full, fifo_empty, push, pop, full_drop;
  state_t      state, next_state;

  assign level      = wr_ptr - rd_ptr;
  assign fifo_full  = (level == DEPTH_L);
  assign fifo_empty = (level == '0);
  assign pop        = (state == ISSUE);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push       = word_done && (!fifo_full || pop);
  assign full_drop  = word_done && fifo_full && !pop;

  always_ff @(posedge pxl_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge pxl_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign fifo_level = 3'(level);

  // ---------------- release gate ----------------
  logic gate;
`ifdef DISPATCH_VBLANK_GATE_EN
  assign gate = vblank;
`else
  logic unused_vblank;
  assign gate          = 1'b1;
  assign unused_vblank = vblank;
`endif

  // ---------------- dispatch FSM ----------------
  // word_out is loaded with the FIFO head on entry to ISSUE, so during ISSUE
  // the strobes and word_out are both valid and the head is popped.
  logic issue_drop;
  logic load_word;

  always_ff @(posedge pxl_clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    score_valid = 1'b0;
    timer_valid = 1'b0;
    oct_valid   = 1'b0;
    issue_drop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) next_state = gate ? ISSUE : WAIT_BLANK;
      end
      WAIT_BLANK: begin
        if (gate) next_state = ISSUE;
      end
      ISSUE: begin
        next_state = IDLE;
        case (word_out[31:30])
          2'b00: score_valid = 1'b1;
          2'b01: timer_valid = 1'b1;
          2'b11: begin
            if (word_out[0] ? (oct_count == RING_FULL) : (oct_count == 4'd0))
              issue_drop = 1'b1;
            else
              oct_valid  = 1'b1;
          end
          default: issue_drop = 1'b1;
        endcase
      end
      default: next_state = IDLE;
    endcase
  end

  assign load_word = (state != ISSUE) && (next_state == ISSUE);

  always_ff @(posedge pxl_clk) begin
    if (reset)          word_out <= '0;
    else if (load_word) word_out <= mem[rd_ptr[AW-1:0]];
  end

  // ---------------- ring occupancy and drop counter ----------------
  logic [8:0] drop_sum;
  assign drop_sum = {1'b0, drop_count} + {8'd0, full_drop} + {8'd0, issue_drop};

  always_ff @(posedge pxl_clk) begin
    if (reset) begin
      oct_count  <= '0;
      drop_count <= '0;
    end else begin
      if (oct_valid) oct_count <= word_out[0] ? oct_count + 4'd1 : oct_count - 4'd1;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_spi_word_dispatcher.sv
// Directed testbench for spi_word_dispatcher. Drives the SPI pins at
// pxl_clk/8, records every strobe with the word it carried, and compares
// against hand-computed expectations. Gated-release scenarios are selected
// by the same DISPATCH_VBLANK_GATE_EN macro as the design.
module tb_spi_word_dispatcher;

  logic        pxl_clk = 1'b0;
  logic        reset, sck, sdi, cs, vblank;
  logic        score_valid, timer_valid, oct_valid, busy;
  logic [31:0] word_out;
  logic [3:0]  oct_count;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] ev_word[$];
  logic [2:0]  ev_kind[$];

  spi_word_dispatcher #(.FIFO_DEPTH(4), .RING_SLOTS(8)) dut (
    .pxl_clk     (pxl_clk),
    .reset       (reset),
    .sck         (sck),
    .sdi         (sdi),
    .cs          (cs),
    .vblank      (vblank),
    .score_valid (score_valid),
    .timer_valid (timer_valid),
    .oct_valid   (oct_valid),
    .word_out    (word_out),
    .oct_count   (oct_count),
    .fifo_level  (fifo_level),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  always #5 pxl_clk = ~pxl_clk;

  // strobe recorder: kind is {score, timer, oct}
  always @(negedge pxl_clk) begin
    if (score_valid || timer_valid || oct_valid) begin
      ev_word.push_back(word_out);
      ev_kind.push_back({score_valid, timer_valid, oct_valid});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge pxl_clk);
  endtask

  // Returns one cycle after the last falling sck edge is driven.
  task automatic send_bits(input logic [31:0] w, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) begin
      if (i > 0) tick(3);
      sdi = w[31-i];
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
      tick(1);
    end
  endtask

  task automatic send_frame(input logic [31:0] w);
    cs = 1'b1;
    tick(4);
    send_bits(w, 32);
    tick(6);
    cs = 1'b0;
    tick(6);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_score"}, score_valid, 1'b0);
    check({tag, "_timer"}, timer_valid, 1'b0);
    check({tag, "_oct"},   oct_valid,   1'b0);
    check({tag, "_word"},  word_out,    32'h0);
    check({tag, "_octc"},  oct_count,   4'd0);
    check({tag, "_lvl"},   fifo_level,  3'd0);
    check({tag, "_drop"},  drop_count,  8'd0);
    check({tag, "_busy"},  busy,        1'b0);
  endtask

  task automatic clear_events;
    ev_word.delete();
    ev_kind.delete();
  endtask

  initial begin
    int unsigned lvl_k, stb_k, k;
    int unsigned stb_at[4];
    logic [31:0] ws[5];

    reset = 1'b1; sck = 1'b0; sdi = 1'b0; cs = 1'b0; vblank = 1'b1;
    tick(3);
    check_reset_values("rst0");
    reset = 1'b0;
    tick(2);

    // ---- single score word, gate open: latency and one-cycle strobe ----
    clear_events();
    cs = 1'b1;
    tick(4);
    send_bits(32'h0064_0123, 32);
    lvl_k = 0; stb_k = 0;
    for (int unsigned i = 1; i <= 20; i++) begin
      tick(1);
      if (fifo_level != 3'd0 && lvl_k == 0) lvl_k = i;
      if (score_valid) begin stb_k = i; break; end
    end
    check("t1_level_cycle",  lvl_k, 3);
    check("t1_strobe_cycle", stb_k, 4);
    check("t1_word", word_out, 32'h0064_0123);
    tick(1);
    check("t1_strobe_width", score_valid, 1'b0);
    check("t1_level_after", fifo_level, 3'd0);
    check("t1_busy_after", busy, 1'b0);
    tick(6);
    cs = 1'b0;
    tick(6);
    check("t1_events", ev_word.size(), 1);
    check("t1_kind", ev_kind[0], 3'b100);
    check("t1_word_held", word_out, 32'h0064_0123);

    // ---- timer word with vblank low ----
    clear_events();
    vblank = 1'b0;
    send_frame(32'h4A0C_8190);
`ifdef DISPATCH_VBLANK_GATE_EN
    check("t2_no_strobe", ev_word.size(), 0);
    check("t2_level", fifo_level, 3'd1);
    check("t2_busy", busy, 1'b1);
    vblank = 1'b1;
    k = 0;
    for (int unsigned i = 1; i <= 10; i++) begin
      tick(1);
      if (timer_valid) begin k = i; break; end
    end
    check("t2_release_cycle", k, 1);
    check("t2_word", word_out, 32'h4A0C_8190);
    tick(2);
`else
    check("t2_events", ev_word.size(), 1);
    check("t2_kind", ev_kind[0], 3'b010);
    check("t2_word", ev_word[0], 32'h4A0C_8190);
    vblank = 1'b1;
`endif

    // ---- ring fill: 9 adds, 9th dropped, then one retire ----
    clear_events();
    for (int unsigned i = 0; i < 9; i++) send_frame(32'hC000_0001 | (i << 8));
    tick(4);
    check("t3_events", ev_word.size(), 8);
    for (int unsigned j = 0; j < 8; j++) begin
      check("t3_ev_word", ev_word[j], 32'hC000_0001 | (j << 8));
      check("t3_ev_kind", ev_kind[j], 3'b001);
    end
    check("t3_oct_full", oct_count, 4'd8);
    check("t3_drop", drop_count, 8'd1);
    send_frame(32'hC000_0000);
    check("t3_retire_events", ev_word.size(), 9);
    check("t3_retire_word", ev_word[8], 32'hC000_0000);
    check("t3_oct_after", oct_count, 4'd7);

    // ---- reset mid-word with non-zero state ----
    cs = 1'b1;
    tick(4);
    send_bits(32'hFFFF_FFFF, 10);
    reset = 1'b1;
    tick(1);
    check_reset_values("rst1");
    reset = 1'b0;
    cs = 1'b0;
    tick(6);

    // ---- illegal words: retire on empty ring, reserved type ----
    clear_events();
    send_frame(32'hC000_0000);
    send_frame(32'h8000_0000);
    check("t4_no_strobe", ev_word.size(), 0);
    check("t4_drop", drop_count, 8'd2);
    check("t4_level", fifo_level, 3'd0);
    check("t4_oct", oct_count, 4'd0);
    check("t4_word", word_out, 32'h8000_0000);

    // ---- burst of five words ----
    clear_events();
`ifdef DISPATCH_VBLANK_GATE_EN
    ws[0] = 32'h0000_0005; ws[1] = 32'h4000_0006; ws[2] = 32'hC000_0001;
    ws[3] = 32'h0000_0008; ws[4] = 32'h4000_0009;
    vblank = 1'b0;
    for (int unsigned i = 0; i < 5; i++) send_frame(ws[i]);
    check("t5_level_full", fifo_level, 3'd4);
    check("t5_drop", drop_count, 8'd3);
    check("t5_no_strobe", ev_word.size(), 0);
    vblank = 1'b1;
    k = 0;
    for (int unsigned i = 1; i <= 20; i++) begin
      tick(1);
      if ((score_valid || timer_valid || oct_valid) && k < 4) begin
        stb_at[k] = i;
        k++;
      end
    end
    check("t5_events", ev_word.size(), 4);
    for (int unsigned j = 0; j < 4; j++) check("t5_order", ev_word[j], ws[j]);
    for (int unsigned j = 1; j < 4; j++) check("t5_spacing", stb_at[j] - stb_at[j-1], 2);
    check("t5_level_empty", fifo_level, 3'd0);
`else
    ws[0] = 32'h0000_0005; ws[1] = 32'h4000_0006; ws[2] = 32'hC000_0001;
    ws[3] = 32'h8000_0000; ws[4] = 32'h7FFF_FFFF;
    for (int unsigned i = 0; i < 5; i++) send_frame(ws[i]);
    check("t5_events", ev_word.size(), 4);
    check("t5_w0", ev_word[0], ws[0]);
    check("t5_k0", ev_kind[0], 3'b100);
    check("t5_w1", ev_word[1], ws[1]);
    check("t5_k1", ev_kind[1], 3'b010);
    check("t5_w2", ev_word[2], ws[2]);
    check("t5_k2", ev_kind[2], 3'b001);
    check("t5_w3", ev_word[3], ws[4]);
    check("t5_k3", ev_kind[3], 3'b010);
    check("t5_drop", drop_count, 8'd3);
`endif
    check("t5_oct", oct_count, 4'd1);

    // ---- partial word discarded, next full word intact ----
    clear_events();
    cs = 1'b1;
    tick(4);
    send_bits(32'hFFFF_FFFF, 17);
    tick(6);
    cs = 1'b0;
    tick(6);
    send_frame(32'h00AB_CDEF);
    check("t6_events", ev_word.size(), 1);
    check("t6_word", ev_word[0], 32'h00AB_CDEF);
    check("t6_kind", ev_kind[0], 3'b100);

    // ---- reset with state built up ----
`ifdef DISPATCH_VBLANK_GATE_EN
    vblank = 1'b0;
    for (int unsigned i = 0; i < 3; i++) send_frame(32'h0000_0010 + i);
    check("t6_level3", fifo_level, 3'd3);
`else
    cs = 1'b1;
    tick(4);
    send_bits(32'h1234_5678, 20);
`endif
    reset = 1'b1;
    tick(1);
    check_reset_values("rst2");
    reset = 1'b0;
    cs = 1'b0;
    vblank = 1'b1;
    tick(6);
    clear_events();
    send_frame(32'h4000_1234);
    check("t6_post_reset_events", ev_word.size(), 1);
    check("t6_post_reset_word", ev_word[0], 32'h4000_1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
